// File: rtl/pipe_stage_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buffer
// Description : Inter-stage pipeline register for the lc3b pipeline. It is a
//               2-entry skid buffer with a valid/ready handshake and a
//               synchronous squash. Define STAGE_PERF_EN to add the stall and
//               squash performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buffer #(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            NUM_DATA   = 2,
  parameter int unsigned            CTRL_WIDTH = 40,
  parameter logic [CTRL_WIDTH-1:0]  NOP_CTRL   = '0,
  parameter int unsigned            CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  // upstream side
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [15:0]                    in_ir,
  input  logic [15:0]                    in_pc,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           squash,
  // downstream side
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0]                    out_ir,
  output logic [15:0]                    out_pc,
  output logic [NUM_DATA*DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  // performance counters
  output logic [CNT_WIDTH-1:0]           stall_cnt,
  output logic [CNT_WIDTH-1:0]           squash_cnt
);

  localparam int unsigned DW = NUM_DATA * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                  state_q, state_d;

  logic [15:0]             head_ir_q,   head_ir_d;
  logic [15:0]             head_pc_q,   head_pc_d;
  logic [DW-1:0]           head_data_q, head_data_d;
  logic [CTRL_WIDTH-1:0]   head_ctrl_q, head_ctrl_d;

  logic [15:0]             skid_ir_q,   skid_ir_d;
  logic [15:0]             skid_pc_q,   skid_pc_d;
  logic [DW-1:0]           skid_data_q, skid_data_d;
  logic [CTRL_WIDTH-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic                    acc;
  logic                    pop;

  // Handshake flags decode only the state flops, so no ready path runs
  // combinationally from downstream to upstream.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    head_ir_d   = head_ir_q;
    head_pc_d   = head_pc_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_ir_d   = skid_ir_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          head_ir_d   = in_ir;
          head_pc_d   = in_pc;
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          head_ir_d   = in_ir;
          head_pc_d   = in_pc;
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
        end else if (acc) begin
          skid_ir_d   = in_ir;
          skid_pc_d   = in_pc;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          state_d     = ST_TWO;
        end else if (pop) begin
          state_d     = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_ir_d   = skid_ir_q;
          head_pc_d   = skid_pc_q;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
          state_d     = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Squash only needs to drop occupancy; stale payload is masked at the outputs.
    if (squash) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      head_ir_q   <= '0;
      head_pc_q   <= '0;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_ir_q   <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      head_ir_q   <= head_ir_d;
      head_pc_q   <= head_pc_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_ir_q   <= skid_ir_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // An empty stage presents a forced bubble rather than whatever the head last held.
  always_comb begin
    out_ir   = 16'h0000;
    out_pc   = 16'h0000;
    out_data = '0;
    out_ctrl = NOP_CTRL;
    if (out_valid) begin
      out_ir   = head_ir_q;
      out_pc   = head_pc_q;
      out_data = head_data_q;
      out_ctrl = head_ctrl_q;
    end
  end

`ifdef STAGE_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_WIDTH-1:0] squash_cnt_q, squash_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (squash && (state_q != ST_EMPTY) && (squash_cnt_q != CNT_MAX)) begin
      squash_cnt_d = squash_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  assign stall_cnt  = '0;
  assign squash_cnt = '0;
`endif

endmodule
`default_nettype wire
